// File: rtl/seq_gen_if.sv
// seq_gen_if: word-load handshake between a word source and seq_gen.
//   load_valid  source offers a word on load_data/load_len
//   load_ready  seq_gen can take a word this cycle
//   load_data   word to serialize, right-aligned
//   load_len    bit count, 1..8 (0 and 9..15 mean 8)
interface seq_gen_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;

  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic [LEN_W-1:0]  load_len;

  modport master (output load_valid, load_data, load_len, input load_ready);
  modport slave  (input load_valid, load_data, load_len, output load_ready);
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serializes loaded words MSB-first onto x, one bit per clock, with
// an optional idle gap after each word.
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low
//   lif        word-load handshake (slave side)
//   abort      synchronous cancel of the current word
//   x          registered serial bit stream (IDLE_BIT when not sending)
//   busy       registered, high while shifting or in the gap
//   done       registered, high during the last bit of a word
//   frame_cnt  registered count of completed words, wraps at 256
module seq_gen #(
  parameter bit          IDLE_BIT = 1'b1,
  parameter int unsigned GAP      = 0
) (
  input  logic        clk,
  input  logic        reset,
  seq_gen_if.slave    lif,
  input  logic        abort,
  output logic        x,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned REM_W  = 3;
  localparam int unsigned GAP_W  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [REM_W-1:0]   rem_q, rem_d;    // bits still to send after the one on x
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               x_q, x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   frame_q, frame_d;

  logic               last_bit;
  logic               ready;
  logic               accept;
  logic               load_now;
  logic [LEN_W-1:0]   eff_len;

  // Length 0 and anything above 8 both mean a full byte
  assign eff_len  = (lif.load_len == '0 || lif.load_len > LEN_W'(8)) ? LEN_W'(8) : lif.load_len;
  assign last_bit = (state_q == S_SHIFT) && (rem_q == '0);
  // Ready is decoded from state and abort only; the last bit opens the
  // handshake early so a following word can start without a bubble
  assign ready    = !abort && ((state_q == S_IDLE) || (last_bit && (GAP == 0)));
  assign accept   = lif.load_valid && ready;

  assign lif.load_ready = ready;
  assign x              = x_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign frame_cnt      = frame_q;

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    x_d      = IDLE_BIT;
    done_d   = 1'b0;
    frame_d  = frame_q;
    load_now = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          load_now = accept;
        end
        S_SHIFT: begin
          if (rem_q != '0) begin
            x_d    = shreg_q[rem_q - REM_W'(1)];
            rem_d  = rem_q - REM_W'(1);
            done_d = (rem_q == REM_W'(1));
          end else begin
            frame_d = frame_q + CNT_W'(1);
            if (GAP > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_W'(GAP - 1);
            end else if (accept) begin
              load_now = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) state_d = S_IDLE;
          else             gap_d   = gap_q - GAP_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Capture the word and put its first (top) bit on x right away
    if (load_now) begin
      state_d = S_SHIFT;
      shreg_d = lif.load_data;
      rem_d   = REM_W'(eff_len - LEN_W'(1));
      x_d     = lif.load_data[REM_W'(eff_len - LEN_W'(1))];
      done_d  = (eff_len == LEN_W'(1));
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      x_q     <= IDLE_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      frame_q <= frame_d;
    end
  end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed scenarios plus a randomized run against a queue-based
// model, on two instances (GAP=0/IDLE_BIT=1 and GAP=2/IDLE_BIT=0).
`timescale 1ns/1ps
module tb_seq_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_gen_if bus0();
  seq_gen_if busg();

  logic       abort0, abortg;
  logic       x0, xg, busy0, busyg, done0, doneg;
  logic [7:0] fc0, fcg;

  seq_gen #(.IDLE_BIT(1'b1), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .lif(bus0.slave), .abort(abort0),
    .x(x0), .busy(busy0), .done(done0), .frame_cnt(fc0));

  seq_gen #(.IDLE_BIT(1'b0), .GAP(2)) dutg (
    .clk(clk), .reset(reset), .lif(busg.slave), .abort(abortg),
    .x(xg), .busy(busyg), .done(doneg), .frame_cnt(fcg));

  int checks = 0;
  int errors = 0;

  task automatic do_reset();
    bus0.load_valid = 1'b0; bus0.load_data = '0; bus0.load_len = '0;
    busg.load_valid = 1'b0; busg.load_data = '0; busg.load_len = '0;
    abort0 = 1'b0; abortg = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    #4 reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (x0 !== 1'b1) begin errors++; $display("FAIL reset_x got %0b want 1", x0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done0); end
    checks++; if (fc0 !== 8'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", fc0); end
    checks++; if (bus0.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus0.load_ready); end
    checks++; if (xg !== 1'b0) begin errors++; $display("FAIL reset_xg got %0b want 0", xg); end
    abort0 = 1'b1; #1;
    checks++; if (bus0.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_abort got %0b want 0", bus0.load_ready); end
    abort0 = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0] e;
    e = 3'b010;
    do_reset();
    bus0.load_valid = 1'b1; bus0.load_data = 8'h02; bus0.load_len = 4'd3; #1;
    checks++; if (bus0.load_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b want 1", bus0.load_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus0.load_valid = 1'b0; bus0.load_data = 8'($urandom); bus0.load_len = 4'($urandom);
      checks++; if (x0 !== e[2-i]) begin errors++; $display("FAIL basic_x[%0d] got %0b want %0b", i, x0, e[2-i]); end
      checks++; if (done0 !== (i == 2)) begin errors++; $display("FAIL basic_done[%0d] got %0b want %0b", i, done0, i == 2); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got %0b want 1", i, busy0); end
    end
    @(posedge clk); #1;
    checks++; if (x0 !== 1'b1) begin errors++; $display("FAIL basic_idle_x got %0b want 1", x0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %0b want 0", busy0); end
    checks++; if (fc0 !== 8'd1) begin errors++; $display("FAIL basic_frame got %0d want 1", fc0); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    e = 7'b1001010;
    do_reset();
    bus0.load_valid = 1'b1; bus0.load_data = 8'h09; bus0.load_len = 4'd4;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin bus0.load_data = 8'h02; bus0.load_len = 4'd3; end
      if (i == 4) bus0.load_valid = 1'b0;
      checks++; if (x0 !== e[6-i]) begin errors++; $display("FAIL b2b_x[%0d] got %0b want %0b", i, x0, e[6-i]); end
      checks++; if (done0 !== (i == 3 || i == 6)) begin errors++; $display("FAIL b2b_done[%0d] got %0b want %0b", i, done0, (i == 3 || i == 6)); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %0b want 1", i, busy0); end
      if (i == 3) begin
        checks++; if (bus0.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_last got %0b want 1", bus0.load_ready); end
      end
    end
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %0b want 0", busy0); end
    checks++; if (fc0 !== 8'd2) begin errors++; $display("FAIL b2b_frame got %0d want 2", fc0); end
  endtask

  task automatic test_len0();
    logic [7:0] e;
    e = 8'hA5;
    do_reset();
    bus0.load_valid = 1'b1; bus0.load_data = 8'hA5; bus0.load_len = 4'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus0.load_valid = 1'b0;
      checks++; if (x0 !== e[7-i]) begin errors++; $display("FAIL len0_x[%0d] got %0b want %0b", i, x0, e[7-i]); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL len0_busy[%0d] got %0b want 1", i, busy0); end
    end
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL len0_end_busy got %0b want 0", busy0); end
  endtask

  task automatic test_gap();
    do_reset();
    busg.load_valid = 1'b1; busg.load_data = 8'h01; busg.load_len = 4'd1;
    @(posedge clk); #1;
    busg.load_valid = 1'b0;
    checks++; if (xg !== 1'b1) begin errors++; $display("FAIL gap_bit_x got %0b want 1", xg); end
    checks++; if (doneg !== 1'b1) begin errors++; $display("FAIL gap_bit_done got %0b want 1", doneg); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (xg !== 1'b0) begin errors++; $display("FAIL gap_x[%0d] got %0b want 0", i, xg); end
      checks++; if (busyg !== 1'b1) begin errors++; $display("FAIL gap_busy[%0d] got %0b want 1", i, busyg); end
      checks++; if (busg.load_ready !== 1'b0) begin errors++; $display("FAIL gap_ready[%0d] got %0b want 0", i, busg.load_ready); end
    end
    @(posedge clk); #1;
    checks++; if (busg.load_ready !== 1'b1) begin errors++; $display("FAIL gap_end_ready got %0b want 1", busg.load_ready); end
    checks++; if (busyg !== 1'b0) begin errors++; $display("FAIL gap_end_busy got %0b want 0", busyg); end
    checks++; if (fcg !== 8'd1) begin errors++; $display("FAIL gap_frame got %0d want 1", fcg); end
  endtask

  task automatic test_abort();
    do_reset();
    bus0.load_valid = 1'b1; bus0.load_data = 8'h09; bus0.load_len = 4'd4;
    @(posedge clk); #1;
    bus0.load_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (x0 !== 1'b0) begin errors++; $display("FAIL abort_bit2 got %0b want 0", x0); end
    abort0 = 1'b1; #1;
    checks++; if (bus0.load_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %0b want 0", bus0.load_ready); end
    @(posedge clk); #1;
    abort0 = 1'b0;
    checks++; if (x0 !== 1'b1) begin errors++; $display("FAIL abort_x got %0b want 1", x0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL abort_done got %0b want 0", done0); end
    checks++; if (fc0 !== 8'd0) begin errors++; $display("FAIL abort_frame got %0d want 0", fc0); end
    // abort in the last-bit cycle suppresses the count
    bus0.load_valid = 1'b1; bus0.load_data = 8'h01; bus0.load_len = 4'd1;
    @(posedge clk); #1;
    bus0.load_valid = 1'b0; abort0 = 1'b1;
    @(posedge clk); #1;
    checks++; if (fc0 !== 8'd0) begin errors++; $display("FAIL abort_last_frame got %0d want 0", fc0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_last_busy got %0b want 0", busy0); end
    // abort in idle blocks acceptance
    bus0.load_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %0b want 0", busy0); end
    abort0 = 1'b0; bus0.load_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus0.load_valid = 1'b1; bus0.load_data = 8'h01; bus0.load_len = 4'd1;
    @(posedge clk); #1;
    bus0.load_data = 8'h00; bus0.load_len = 4'd8;
    @(posedge clk); #1;
    bus0.load_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (fc0 !== 8'd1) begin errors++; $display("FAIL rmid_pre_frame got %0d want 1", fc0); end
    checks++; if (x0 !== 1'b0) begin errors++; $display("FAIL rmid_pre_x got %0b want 0", x0); end
    #2 reset = 1'b0; #1;
    checks++; if (x0 !== 1'b1) begin errors++; $display("FAIL rmid_x got %0b want 1", x0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy0); end
    checks++; if (fc0 !== 8'd0) begin errors++; $display("FAIL rmid_frame got %0d want 0", fc0); end
    #1 reset = 1'b1;
    bus0.load_valid = 1'b1; bus0.load_data = 8'h02; bus0.load_len = 4'd2;
    @(posedge clk); #1;
    bus0.load_valid = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rmid_first_accept got %0b want 1", busy0); end
    checks++; if (x0 !== 1'b1) begin errors++; $display("FAIL rmid_first_bit got %0b want 1", x0); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic       prev;
    do_reset();
    bus0.load_valid = 1'b1; bus0.load_len = 4'd1;
    d = 8'($urandom); bus0.load_data = d; prev = d[0];
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk); #1;
      checks++; if (x0 !== prev) begin errors++; $display("FAIL wrap_x[%0d] got %0b want %0b", k, x0, prev); end
      d = 8'($urandom); bus0.load_data = d; prev = d[0];
      if (k == 256) begin
        bus0.load_valid = 1'b0;
        checks++; if (fc0 !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", fc0); end
      end
    end
    @(posedge clk); #1;
    checks++; if (fc0 !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", fc0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL wrap_busy got %0b want 0", busy0); end
  endtask

  // Model: per instance, a queue of the {x,busy,done} values still to be
  // shown, plus a word counter.
  task automatic test_random();
    logic [2:0] q0[$];
    logic [2:0] qg[$];
    logic [2:0] q[$];
    int         mfc[2];
    logic       v, ab, rdy, ib;
    logic [7:0] dat;
    logic [3:0] len;
    logic [2:0] exp, obs;
    int         gap, len_eff;
    do_reset();
    mfc[0] = 0; mfc[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      v   = ($urandom_range(0, 2) != 0);
      dat = 8'($urandom);
      len = 4'($urandom);
      ab  = ($urandom_range(0, 15) == 0);
      bus0.load_valid = v; bus0.load_data = dat; bus0.load_len = len; abort0 = ab;
      busg.load_valid = v; busg.load_data = dat; busg.load_len = len; abortg = ab;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin q = q0; ib = 1'b1; gap = 0; rdy = bus0.load_ready; end
        else        begin q = qg; ib = 1'b0; gap = 2; rdy = busg.load_ready; end
        exp[0] = !ab && (q.size() == 0 || (q.size() == 1 && q[0][0]));
        checks++; if (rdy !== exp[0]) begin errors++; $display("FAIL rnd_ready[d%0d c%0d] got %0b want %0b", d, c, rdy, exp[0]); end
        if (ab) q.delete();
        else begin
          if (q.size() > 0) begin
            if (q[0][0]) mfc[d] = (mfc[d] + 1) % 256;
            void'(q.pop_front());
          end
          if (v && exp[0]) begin
            len_eff = (len == 0 || len > 8) ? 8 : int'(len);
            for (int b = len_eff - 1; b >= 0; b--) q.push_back({dat[b], 1'b1, b == 0});
            for (int g = 0; g < gap; g++) q.push_back({ib, 1'b1, 1'b0});
          end
        end
        if (d == 0) q0 = q; else qg = q;
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin q = q0; ib = 1'b1; obs = {x0, busy0, done0}; end
        else        begin q = qg; ib = 1'b0; obs = {xg, busyg, doneg}; end
        exp = (q.size() == 0) ? {ib, 2'b00} : q[0];
        checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_out[d%0d c%0d] got x/busy/done %b want %b", d, c, obs, exp); end
        checks++; if ((d == 0 ? fc0 : fcg) !== 8'(mfc[d])) begin errors++; $display("FAIL rnd_frame[d%0d c%0d] got %0d want %0d", d, c, (d == 0 ? fc0 : fcg), mfc[d]); end
      end
    end
    abort0 = 1'b0; abortg = 1'b0; bus0.load_valid = 1'b0; busg.load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    abort0 = 1'b0; abortg = 1'b0;
    bus0.load_valid = 1'b0; bus0.load_data = '0; bus0.load_len = '0;
    busg.load_valid = 1'b0; busg.load_data = '0; busg.load_len = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_len0();
    test_gap();
    test_abort();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter IDLE_BIT, default 1: level driven on x when no word is being sent.
REQ-002 Parameter GAP, default 0, range 0..15: idle cycles inserted after each completed word.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  a word is offered on load_data/load_len.
REQ-006 load_ready  output  1  the block accepts a word; transfer occurs on a rising edge where load_valid & load_ready.
REQ-007 load_data  input  8  word to serialize, right-aligned.
REQ-008 load_len  input  4  number of bits to send, 1..8; 0 means 8; values 9..15 are clamped to 8.
REQ-009 abort  input  1  synchronous cancel of the current word.
REQ-010 x  output  1  registered serial bitstream, one bit per clk, consumed by a detector that samples every edge.
REQ-011 busy  output  1  high while a word is being shifted or a gap is running.
REQ-012 done  output  1  one-cycle pulse coincident with the last bit of a word on x.
REQ-013 frame_cnt  output  8  count of completed words.

Function
REQ-014 States SHALL be IDLE, SHIFT and GAP.
REQ-015 IDLE: load_ready=1, x=IDLE_BIT, busy=0; on accept, capture the word and go to SHIFT.
REQ-016 Bit order SHALL be load_data[L-1] first down to load_data[0], where L is the effective length.
REQ-017 Latency: the first bit SHALL appear on x in the cycle immediately after the accepting edge; each later bit follows on the next cycle.
REQ-018 SHIFT: busy=1; load_ready=0 except in the last-bit cycle when GAP=0.
REQ-019 Last-bit cycle: done=1; at the closing edge frame_cnt increments by 1, wrapping 255 -> 0.
REQ-020 After the last bit, the next state SHALL be GAP if GAP>0, else SHIFT if a new word is accepted on that edge, else IDLE.
REQ-021 Back-to-back with GAP=0: the first bit of the next word SHALL follow the previous last bit with no idle cycle.
REQ-022 GAP: x=IDLE_BIT, busy=1, load_ready=0, for exactly GAP cycles, then IDLE.
REQ-023 abort=1 SHALL force load_ready=0 in that cycle, so no word is accepted.
REQ-024 abort=1 SHALL move the block to IDLE at the next edge with x=IDLE_BIT, with no done pulse and no frame_cnt change.
REQ-025 abort=1 has priority over all other transitions, including a last-bit cycle.
REQ-026 load_data and load_len SHALL be ignored unless a transfer occurs.
REQ-027 The captured word SHALL be unaffected by input changes during SHIFT.
REQ-028 All outputs except load_ready SHALL be register outputs; load_ready is decoded from state and abort only.

Reset
REQ-029 While reset=0, regardless of clk:
- state=IDLE, x=IDLE_BIT, busy=0, done=0, frame_cnt=0
- shift register and counters cleared
- load_ready=1, unless abort=1 (REQ-023)
REQ-030 Reset asserted mid-word SHALL discard the word immediately.
REQ-031 After reset release, the first accept SHALL be possible on the first rising edge.

Verification
REQ-032 Load 8'h02, len 3, GAP=0 -> x after accept: 0,1,0; done high on third bit; frame_cnt=1; then x=1 idle.
REQ-033 Back-to-back, load_valid held, 8'h09 len 4 then 8'h02 len 3 -> x=1,0,0,1,0,1,0 with no idle; done pulses on bits 4 and 7; frame_cnt=2.
REQ-034 Load 8'hA5 with len 0 -> x=1,0,1,0,0,1,0,1 (8 bits); busy high for 8 cycles.
REQ-035 GAP=2, load 8'h01 len 1 -> x=1 bit, then 2 cycles of IDLE_BIT with busy=1 and load_ready=0, then load_ready=1.
REQ-036 Abort and reset cases:
- abort on bit 2 of 8'h09 len 4 -> x=IDLE_BIT from next cycle, no done, frame_cnt unchanged
- reset=0 asserted mid-word -> x=1, busy=0, frame_cnt=0 without a clock edge
REQ-037 Send 256 words of len 1 -> frame_cnt returns to 0 after the 256th done.
